register_bank_pipe: RTL and testbench
=====================================

# register_bank_pipe

Parametrised successor of the single-cycle register bank, sized for the pipelined core. It provides two asynchronous read ports and one synchronous write port over `NREGS` registers of `XLEN` bits, with register 0 hard-wired to zero. It adds a per-register busy scoreboard (reserve at issue, release at writeback, bulk flush) and optional write-to-read forwarding. It sits between decode (A1/A2/reserve) and writeback (A3/WD3/WE3).

## Interface
- `XLEN`, 32: register width in bits; legal values are 8 to 64.
- `NREGS`, 32: number of registers; must be a power of two, from 2 to 32.
- `AW`, `$clog2(NREGS)`: address width; derived, never overridden.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `A1`  in  AW  read port 1 address.
- `A2`  in  AW  read port 2 address.
- `RD1`  out  XLEN  read data for A1.
- `RD2`  out  XLEN  read data for A2.
- `BUSY1`  out  1  register A1 has a pending producer.
- `BUSY2`  out  1  register A2 has a pending producer.
- `A3`  in  AW  write address.
- `WE3`  in  1  write enable.
- `WD3`  in  XLEN  write data.
- `RES`  in  1  reserve: mark register RA busy.
- `RA`  in  AW  reserve address.
- `FLUSH`  in  1  clear all busy bits.

## Operation
- **Storage.** Registers `regs[0..NREGS-1]` of XLEN bits, plus busy bits `busy[0..NREGS-1]`.
- **Register 0.**
  - Always reads as 0.
  - Writes to it are ignored.
  - Its busy bit is constant 0; a reserve to it is ignored.
- **Write.** On a rising edge with `WE3=1` and `A3!=0`: `regs[A3] <= WD3`, and `busy[A3]` is cleared.
- **Reserve.** On a rising edge with `RES=1` and `RA!=0`, `busy[RA]` is set.
- **Busy-bit priority per register**, highest first:
  1. FLUSH clears every bit.
  2. Otherwise a reserve sets the bit.
  3. Otherwise a write clears the bit.
  4. Otherwise the bit holds.
- **Consequences of the priority order.**
  - Reserve and write to the same register in one cycle: data is written and the bit ends at 1, because a new producer is in flight.
  - FLUSH together with RES: all bits end at 0.
  - FLUSH together with WE3: the data write still happens.
- **Reads.**
  - RD1/RD2 and BUSY1/BUSY2 are combinational from the addresses and state.
  - There is no read latency.
  - Both ports may address the same register; both then return identical data.
- **Reset (`rst=0`).**
  - Asynchronously clears every register and busy bit.
  - Writes, reserves and flushes are ignored while reset is asserted.
  - RD1, RD2, BUSY1 and BUSY2 all read 0.
  - Reset asserted mid-sequence discards any pending reserve or write that cycle.
- **Arithmetic.** There is none. All addresses are AW bits wide, so no address is ever out of range.

## Timing
- **Write.** Visible on RD1/RD2 from the cycle after the capturing edge. With `REGBANK_BYPASS_EN`, it is also visible in the same cycle (see Configuration).
- **Reserve.** BUSY1/BUSY2 go high in the cycle after the edge that captures RES.
- **Release.** BUSY goes low in the cycle after the write edge, unless bypass applies.
- **Flush.** Takes effect at the next edge; every BUSY reads 0 in the following cycle.
- **Reset release.** The first edge with `rst=1` may write or reserve.

## Configuration
- **Macro:** `REGBANK_BYPASS_EN`.
- **Defined:** same-cycle forwarding.
  - If `WE3=1`, `A3!=0` and `A3==A1`, then `RD1=WD3`.
  - In the same condition, BUSY1 reads 0 unless `RES=1` with `RA==A1` in that cycle.
  - Port 2 behaves identically with A2, RD2 and BUSY2.
  - Forwarding is suppressed while `rst=0`.
- **Not defined:**
  - Reads return stored state only; a write appears one cycle after its edge.
  - BUSY reflects the stored busy bits only.

## Test plan
- **Reset and basic write/read.** Hold `rst=0` for 2 cycles, then write reg5=0xA5A5A5A5 and reg10=0x5A5A5A5A, then read A1=5, A2=10 → RD1=0xA5A5A5A5, RD2=0x5A5A5A5A; unwritten reg15 reads 0x00000000.
- **Register 0.** Write reg0=0xFFFFFFFF and RES with RA=0 → RD1(A1=0)=0 and BUSY1=0 on every following cycle.
- **Scoreboard.**
  - RES RA=7, then BUSY1(A1=7)=1.
  - Next: write reg7=0x12345678 → BUSY1=0 and RD1=0x12345678 in the cycle after the edge.
  - Simultaneous RES and WE3 to reg7 → BUSY1 stays 1 and RD1 shows the new data.
- **Flush priority.** Reserve regs 3, 4 and 9, then FLUSH together with RES RA=12 → BUSY=0 for regs 3, 4, 9 and 12.
- **Bypass**, with `REGBANK_BYPASS_EN` defined: in the same cycle, WE3=1, A3=A1=6, WD3=0xCAFEBABE → RD1=0xCAFEBABE before the edge. Without the macro, RD1 shows the old value until after the edge.
- **Reset mid-operation.** With reg5=0x1 and busy[5]=1, pulse `rst=0` between edges → RD1(A1=5)=0 and BUSY1=0 immediately; a write presented during reset is not stored.

Source files
------------

// File: rtl/register_bank_pipe.sv
// ============================================================================
// Module      : register_bank_pipe
// Description : NREGS x XLEN register bank with two combinational read ports,
//               one write port, a per-register busy scoreboard and optional
//               same-cycle write forwarding (macro REGBANK_BYPASS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_bank_pipe #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            BUSY1,
  output logic            BUSY2,
  input  logic [AW-1:0]   A3,
  input  logic            WE3,
  input  logic [XLEN-1:0] WD3,
  input  logic            RES,
  input  logic [AW-1:0]   RA,
  input  logic            FLUSH
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic             w_wr_en;
  logic             w_res_en;
  logic [XLEN-1:0]  w_rd1_stored;
  logic [XLEN-1:0]  w_rd2_stored;

  assign w_wr_en  = WE3 && (A3 != '0);
  assign w_res_en = RES && (RA != '0);

  // Busy-bit priority: flush, then reserve, then write release, then hold.
  always_comb begin
    busy_d = busy_q;
    if (FLUSH) begin
      busy_d = '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (w_res_en && (RA == AW'(i))) begin
          busy_d[i] = 1'b1;
        end else if (w_wr_en && (A3 == AW'(i))) begin
          busy_d[i] = 1'b0;
        end
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Entry 0 is only ever cleared; the read path never selects it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (w_wr_en) begin
      regs_q[A3] <= WD3;
    end
  end

  assign w_rd1_stored = (A1 == '0) ? '0 : regs_q[A1];
  assign w_rd2_stored = (A2 == '0) ? '0 : regs_q[A2];

`ifdef REGBANK_BYPASS_EN
  logic w_fwd1;
  logic w_fwd2;

  // A forwarded write releases the bit unless a new producer reserves it now.
  assign w_fwd1 = rst && w_wr_en && (A3 == A1);
  assign w_fwd2 = rst && w_wr_en && (A3 == A2);

  always_comb begin
    RD1   = w_rd1_stored;
    RD2   = w_rd2_stored;
    BUSY1 = busy_q[A1];
    BUSY2 = busy_q[A2];
    if (w_fwd1) begin
      RD1   = WD3;
      BUSY1 = w_res_en && (RA == A1);
    end
    if (w_fwd2) begin
      RD2   = WD3;
      BUSY2 = w_res_en && (RA == A2);
    end
  end
`else
  assign RD1   = w_rd1_stored;
  assign RD2   = w_rd2_stored;
  assign BUSY1 = busy_q[A1];
  assign BUSY2 = busy_q[A2];
`endif

endmodule

`default_nettype wire

// File: tb/tb_register_bank_pipe.sv
// ============================================================================
// Module      : tb_register_bank_pipe
// Description : Directed scoreboard bench for register_bank_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_bank_pipe;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int AW    = 5;

  localparam int SEL_RD1   = 0;
  localparam int SEL_RD2   = 1;
  localparam int SEL_BUSY1 = 2;
  localparam int SEL_BUSY2 = 3;

  typedef struct {
    string           tag;
    int              sel;
    logic [XLEN-1:0] exp;
  } sb_item_t;

  logic            clk;
  logic            rst;
  logic [AW-1:0]   A1, A2, A3, RA;
  logic [XLEN-1:0] RD1, RD2, WD3;
  logic            BUSY1, BUSY2, WE3, RES, FLUSH;

  sb_item_t sb_q[$];
  int checks = 0;
  int errors = 0;

  register_bank_pipe #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk   (clk),
    .rst   (rst),
    .A1    (A1),
    .A2    (A2),
    .RD1   (RD1),
    .RD2   (RD2),
    .BUSY1 (BUSY1),
    .BUSY2 (BUSY2),
    .A3    (A3),
    .WE3   (WE3),
    .WD3   (WD3),
    .RES   (RES),
    .RA    (RA),
    .FLUSH (FLUSH)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic expect_val(input string tag, input int sel, input logic [XLEN-1:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.sel = sel;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  function automatic logic [XLEN-1:0] observe(input int sel);
    case (sel)
      SEL_RD1:   return RD1;
      SEL_RD2:   return RD2;
      SEL_BUSY1: return {{(XLEN-1){1'b0}}, BUSY1};
      default:   return {{(XLEN-1){1'b0}}, BUSY2};
    endcase
  endfunction

  // Settle combinational outputs, then retire every queued expectation.
  task automatic check_now();
    sb_item_t it;
    logic [XLEN-1:0] obs;
    #1;
    while (sb_q.size() > 0) begin
      it  = sb_q.pop_front();
      obs = observe(it.sel);
      checks++;
      assert (obs === it.exp) else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE3 = 1'b0; RES = 1'b0; FLUSH = 1'b0;
    A3 = '0; RA = '0; WD3 = '0;
  endtask

  initial begin
    rst = 1'b0;
    A1 = '0; A2 = '0;
    idle();

    // Reset held for two cycles
    tick(); tick();
    A1 = 5'd5; A2 = 5'd10;
    expect_val("reset_rd1", SEL_RD1, 32'h0);
    expect_val("reset_rd2", SEL_RD2, 32'h0);
    expect_val("reset_busy1", SEL_BUSY1, 32'h0);
    check_now();
    rst = 1'b1;

    // Basic writes and reads
    WE3 = 1'b1; A3 = 5'd5; WD3 = 32'hA5A5A5A5;
    tick();
    A3 = 5'd10; WD3 = 32'h5A5A5A5A;
    tick();
    idle();
    expect_val("rd_reg5", SEL_RD1, 32'hA5A5A5A5);
    expect_val("rd_reg10", SEL_RD2, 32'h5A5A5A5A);
    check_now();
    A1 = 5'd15; A2 = 5'd5;
    expect_val("rd_reg15_unwritten", SEL_RD1, 32'h0);
    expect_val("rd2_reg5", SEL_RD2, 32'hA5A5A5A5);
    check_now();
    A1 = 5'd10; A2 = 5'd10;
    expect_val("same_addr_rd1", SEL_RD1, 32'h5A5A5A5A);
    expect_val("same_addr_rd2", SEL_RD2, 32'h5A5A5A5A);
    check_now();

    // Register 0 ignores write and reserve
    WE3 = 1'b1; A3 = 5'd0; WD3 = 32'hFFFFFFFF; RES = 1'b1; RA = 5'd0;
    A1 = 5'd0;
    tick();
    idle();
    expect_val("reg0_rd", SEL_RD1, 32'h0);
    expect_val("reg0_busy", SEL_BUSY1, 32'h0);
    check_now();
    tick();
    expect_val("reg0_rd_later", SEL_RD1, 32'h0);
    expect_val("reg0_busy_later", SEL_BUSY1, 32'h0);
    check_now();

    // Scoreboard reserve / release / simultaneous
    A1 = 5'd7;
    expect_val("r7_idle_busy", SEL_BUSY1, 32'h0);
    check_now();
    RES = 1'b1; RA = 5'd7;
    tick();
    idle();
    expect_val("r7_reserved", SEL_BUSY1, 32'h1);
    check_now();
    WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h12345678;
    tick();
    idle();
    expect_val("r7_released", SEL_BUSY1, 32'h0);
    expect_val("r7_data", SEL_RD1, 32'h12345678);
    check_now();
    WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h0BADF00D; RES = 1'b1; RA = 5'd7;
    tick();
    idle();
    expect_val("r7_res_wr_busy", SEL_BUSY1, 32'h1);
    expect_val("r7_res_wr_data", SEL_RD1, 32'h0BADF00D);
    check_now();

    // Flush beats reserve
    RES = 1'b1; RA = 5'd3; tick();
    RA = 5'd4; tick();
    RA = 5'd9; tick();
    idle();
    A1 = 5'd3; A2 = 5'd4;
    expect_val("r3_reserved", SEL_BUSY1, 32'h1);
    expect_val("r4_reserved", SEL_BUSY2, 32'h1);
    check_now();
    FLUSH = 1'b1; RES = 1'b1; RA = 5'd12;
    tick();
    idle();
    expect_val("flush_r3", SEL_BUSY1, 32'h0);
    expect_val("flush_r4", SEL_BUSY2, 32'h0);
    check_now();
    A1 = 5'd9; A2 = 5'd12;
    expect_val("flush_r9", SEL_BUSY1, 32'h0);
    expect_val("flush_r12", SEL_BUSY2, 32'h0);
    check_now();
    A1 = 5'd7;
    expect_val("flush_r7", SEL_BUSY1, 32'h0);
    check_now();

    // Forwarding behaviour (or its absence)
    WE3 = 1'b1; A3 = 5'd6; WD3 = 32'h11111111; RES = 1'b1; RA = 5'd6;
    tick();
    idle();
    A1 = 5'd6;
    WE3 = 1'b1; A3 = 5'd6; WD3 = 32'hCAFEBABE;
`ifdef REGBANK_BYPASS_EN
    expect_val("bypass_rd1_pre_edge", SEL_RD1, 32'hCAFEBABE);
    expect_val("bypass_busy1_pre_edge", SEL_BUSY1, 32'h0);
`else
    expect_val("nobypass_rd1_pre_edge", SEL_RD1, 32'h11111111);
    expect_val("nobypass_busy1_pre_edge", SEL_BUSY1, 32'h1);
`endif
    check_now();
    tick();
    idle();
    expect_val("r6_rd1_post_edge", SEL_RD1, 32'hCAFEBABE);
    expect_val("r6_busy1_post_edge", SEL_BUSY1, 32'h0);
    check_now();

    // Reset mid-operation
    WE3 = 1'b1; A3 = 5'd5; WD3 = 32'h1; RES = 1'b1; RA = 5'd5;
    tick();
    idle();
    A1 = 5'd5; A2 = 5'd10;
    expect_val("r5_pre_reset_rd", SEL_RD1, 32'h1);
    expect_val("r5_pre_reset_busy", SEL_BUSY1, 32'h1);
    check_now();
    WE3 = 1'b1; A3 = 5'd5; WD3 = 32'h77; RES = 1'b1; RA = 5'd5;
    rst = 1'b0;
    expect_val("mid_reset_rd1", SEL_RD1, 32'h0);
    expect_val("mid_reset_busy1", SEL_BUSY1, 32'h0);
    expect_val("mid_reset_rd2", SEL_RD2, 32'h0);
    check_now();
    tick();
    rst = 1'b1;
    idle();
    expect_val("post_reset_write_dropped", SEL_RD1, 32'h0);
    expect_val("post_reset_res_dropped", SEL_BUSY1, 32'h0);
    check_now();

    // First edge after reset release may write
    WE3 = 1'b1; A3 = 5'd5; WD3 = 32'h0000BEEF;
    tick();
    idle();
    expect_val("first_write_after_reset", SEL_RD1, 32'h0000BEEF);
    check_now();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
